// File: rtl/bcd_pkg.sv
// bcd_pkg: shared types, constants and the add-3/shift step for the BCD conversion engine
package bcd_pkg;
  typedef enum logic [0:0] {IDLE, SHIFT} state_t;
  localparam int BCD_DIGIT_W = 4;
  localparam int ADD3_THRESH = 5;
  localparam int MAX_DIGITS = 10;
  localparam int ACC_MAX_W = BCD_DIGIT_W * MAX_DIGITS;
  // Callers zero-extend narrower accumulators; zero digits never cross the add-3 threshold.
  function automatic logic [ACC_MAX_W-1:0] dabble_step(input logic [ACC_MAX_W-1:0] acc, input logic b);
    logic [ACC_MAX_W-1:0] a;
    a = acc;
    for (int d = 0; d < MAX_DIGITS; d++)
      if (a[d*BCD_DIGIT_W +: BCD_DIGIT_W] >= BCD_DIGIT_W'(ADD3_THRESH))
        a[d*BCD_DIGIT_W +: BCD_DIGIT_W] = a[d*BCD_DIGIT_W +: BCD_DIGIT_W] + 4'd3;
    return {a[ACC_MAX_W-2:0], b};
  endfunction
endpackage

// File: rtl/bcd_rr_arbiter.sv
// bcd_rr_arbiter: combinational round-robin pick, searching upward from rr_i with wrap
module bcd_rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   rr_i,
  output logic [IW-1:0]   winner_o,
  output logic            any_req_o
);
  always_comb begin
    winner_o = '0;
    for (int k = NREQ - 1; k >= 0; k--)
      if (req_i[(int'(rr_i) + k) % NREQ]) winner_o = IW'((int'(rr_i) + k) % NREQ);
  end
  assign any_req_o = |req_i;
endmodule

// File: rtl/bcd_conv_sched.sv
// bcd_conv_sched: shared multi-cycle binary-to-BCD converter with round-robin requesters
module bcd_conv_sched
  import bcd_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int WIDTH = 8,
  parameter int DIGITS = 3
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NREQ-1:0]               req_i,
  input  logic [NREQ*WIDTH-1:0]         bin_i,
  output logic [NREQ-1:0]               ack_o,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_o,
  output logic                          busy_o,
  output logic [$clog2(NREQ)-1:0]       owner_o
);
  localparam int IW = $clog2(NREQ);
  localparam int AW = BCD_DIGIT_W * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);
  if (DIGITS > MAX_DIGITS || 64'd10 ** DIGITS <= (64'd1 << WIDTH) - 64'd1) begin : g_bad_digits
    $error("bcd_conv_sched: DIGITS cannot hold the largest WIDTH-bit operand");
  end
  state_t state_q, state_d;
  logic [WIDTH-1:0] op_q, op_d;
  logic [AW-1:0] acc_q, acc_d, bcd_q, bcd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] rr_q, rr_d, owner_q, owner_d, winner;
  logic [NREQ-1:0] ack_q, ack_d;
  logic any_req;
  bcd_rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
    .req_i(req_i),
    .rr_i(rr_q),
    .winner_o(winner),
    .any_req_o(any_req)
  );
  always_comb begin
    state_d = state_q;
    op_d = op_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    rr_d = rr_q;
    owner_d = owner_q;
    ack_d = '0;
    bcd_d = bcd_q;
    if (state_q == IDLE) begin
      if (any_req) begin
        op_d = bin_i[int'(winner)*WIDTH +: WIDTH];
        acc_d = '0;
        owner_d = winner;
        cnt_d = '0;
        state_d = SHIFT;
      end
    end else begin
      acc_d = AW'(dabble_step(ACC_MAX_W'(acc_q), op_q[WIDTH-1]));
      op_d = op_q << 1;
      cnt_d = cnt_q + CW'(1);
      if (cnt_q == CW'(WIDTH - 1)) begin
        bcd_d = acc_d;
        ack_d[owner_q] = 1'b1;
        rr_d = owner_q == IW'(NREQ - 1) ? '0 : owner_q + IW'(1);
        state_d = IDLE;
      end
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      op_q <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      rr_q <= '0;
      owner_q <= '0;
      ack_q <= '0;
      bcd_q <= '0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      rr_q <= rr_d;
      owner_q <= owner_d;
      ack_q <= ack_d;
      bcd_q <= bcd_d;
    end
  end
  assign ack_o = ack_q;
  assign bcd_o = bcd_q;
  assign busy_o = state_q == SHIFT;
  assign owner_o = owner_q;
endmodule

// File: tb/tb_bcd_conv_sched.sv
// tb_bcd_conv_sched: scoreboard bench with a timed arithmetic reference of the shared converter
module tb_bcd_conv_sched;
  localparam int NREQ = 2;
  localparam int WIDTH = 8;
  localparam int DIGITS = 3;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [NREQ-1:0] req = '0;
  logic [NREQ*WIDTH-1:0] bin = '0;
  logic [NREQ-1:0] ack_o;
  logic [4*DIGITS-1:0] bcd_o;
  logic busy_o;
  logic [$clog2(NREQ)-1:0] owner_o;

  bcd_conv_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clock(clock),
    .reset(reset),
    .req_i(req),
    .bin_i(bin),
    .ack_o(ack_o),
    .bcd_o(bcd_o),
    .busy_o(busy_o),
    .owner_o(owner_o)
  );

  always #5 clock = ~clock;

  typedef struct {
    int w;
    logic [4*DIGITS-1:0] bcd;
    int due;
  } exp_t;
  exp_t sb[$];
  exp_t e;
  int cyc = 0, checks = 0, failures = 0;
  int m_rr = 0, m_owner = 0, m_busy_until = 0, mw;
  logic [4*DIGITS-1:0] m_bcd = '0;

  function automatic logic [4*DIGITS-1:0] to_bcd(input int v);
    logic [4*DIGITS-1:0] r;
    for (int d = 0; d < DIGITS; d++) begin
      r[4*d +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: a single server, free WIDTH+1 edges after each grant, winner found by scanning from rr
  always @(posedge clock) begin
    cyc++;
    if (reset) begin
      sb.delete();
      m_rr = 0;
      m_owner = 0;
      m_busy_until = 0;
      m_bcd = '0;
    end else begin
      if (sb.size() > 0 && sb[0].due == cyc) m_bcd = sb[0].bcd;
      if (cyc >= m_busy_until && |req) begin
        mw = -1;
        for (int k = 0; k < NREQ; k++)
          if (mw < 0 && req[(m_rr + k) % NREQ]) mw = (m_rr + k) % NREQ;
        sb.push_back('{mw, to_bcd(int'(bin[mw*WIDTH +: WIDTH])), cyc + WIDTH});
        m_owner = mw;
        m_rr = (mw + 1) % NREQ;
        m_busy_until = cyc + WIDTH + 1;
      end
    end
  end

  always @(negedge clock) begin
    chk("busy", busy_o, cyc < m_busy_until - 1);
    chk("owner", owner_o, m_owner);
    chk("bcd_hold", bcd_o, m_bcd);
    if (ack_o != '0) begin
      if (sb.size() == 0) chk("ack_unexpected", ack_o, 0);
      else begin
        e = sb.pop_front();
        chk("ack_owner", ack_o, 1 << e.w);
        chk("ack_bcd", bcd_o, e.bcd);
        chk("ack_time", cyc, e.due);
      end
    end else if (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      chk("ack_missing", ack_o, 1 << e.w);
    end
  end

  task automatic wait_ack(input int i, input bit drop);
    int n = 0;
    while (!ack_o[i] && n < 100) begin
      @(negedge clock);
      n++;
    end
    chk("ack_wait", ack_o[i], 1);
    if (drop) req[i] = 1'b0;
  endtask

  task automatic conv(input int i, input int v);
    bin[i*WIDTH +: WIDTH] = WIDTH'(v);
    req[i] = 1'b1;
    @(negedge clock);
    wait_ack(i, 1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req = '0;
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clock);
    chk("rst_ack", ack_o, 0);
    chk("rst_bcd", bcd_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_owner", owner_o, 0);
    reset = 1'b0;
    conv(0, 255);
    chk("bcd_255", bcd_o, 12'h255);
    conv(0, 0);
    conv(1, 99);
    chk("bcd_99", bcd_o, 12'h099);
    conv(0, 128);
    conv(1, 200);
    chk("bcd_200", bcd_o, 12'h200);
    do_reset();
    bin = {8'd42, 8'd10};
    req = 2'b11;
    wait_ack(0, 1);
    chk("both_first", bcd_o, 12'h010);
    @(negedge clock);
    wait_ack(1, 1);
    chk("both_second", bcd_o, 12'h042);
    req = 2'b11;
    repeat (60) begin
      @(negedge clock);
      bin = 16'($urandom);
    end
    req = '0;
    repeat (12) @(negedge clock);
    bin[7:0] = 8'd77;
    req[0] = 1'b1;
    repeat (5) @(negedge clock);
    reset = 1'b1;
    req = '0;
    @(negedge clock);
    chk("abort_ack", ack_o, 0);
    chk("abort_bcd", bcd_o, 0);
    chk("abort_busy", busy_o, 0);
    chk("abort_owner", owner_o, 0);
    reset = 1'b0;
    repeat (12) @(negedge clock);
    conv(0, 123);
    chk("bcd_123", bcd_o, 12'h123);
    bin[7:0] = 8'd55;
    req[0] = 1'b1;
    repeat (3) @(negedge clock);
    bin[7:0] = 8'd200;
    wait_ack(0, 0);
    chk("hold_first", bcd_o, 12'h055);
    bin[7:0] = 8'd33;
    @(negedge clock);
    chk("hold_regrant_busy", busy_o, 1);
    wait_ack(0, 1);
    chk("hold_second", bcd_o, 12'h033);
    repeat (300) begin
      @(negedge clock);
      for (int i = 0; i < NREQ; i++)
        if (req[i] && ack_o[i]) req[i] = ($urandom % 4 == 0);
        else if (!req[i]) req[i] = ($urandom % 3 == 0);
      bin = 16'($urandom);
    end
    req = '0;
    repeat (30) @(negedge clock);
    chk("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
